// File: rtl/tick_stopwatch.sv
// BCD mm:ss stopwatch advanced by prescaled rising edges of a same-domain tick level.
// Start/stop/clear control through a three-state FSM; all outputs registered.
module tick_stopwatch #(
  parameter int unsigned TICKS_PER_STEP = 1,
  parameter int unsigned PRE_W          = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       wrap
);

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_STEP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE
  } state_t;

  state_t           state_q, state_d;
  logic             tick_q;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [3:0]       sec_ones_q, sec_ones_d;
  logic [3:0]       sec_tens_q, sec_tens_d;
  logic [3:0]       min_ones_q, min_ones_d;
  logic [3:0]       min_tens_q, min_tens_d;
  logic             running_q, running_d;
  logic             wrap_q, wrap_d;
  logic             rise;
  logic             count_en;
  logic             step;

  assign rise     = tick_in & ~tick_q;
  // A rise coinciding with stop/clear, or with a start leaving IDLE/PAUSE, is dropped.
  assign count_en = (state_q == S_RUN) & rise & ~stop & ~clear;

  // Next state: clear > stop > start; stop blocks start even where stop is ignored.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else if (stop) begin
      if (state_q == S_RUN) state_d = S_PAUSE;
    end else if (start) begin
      if (state_q != S_RUN) state_d = S_RUN;
    end
  end

  // Prescaler
  always_comb begin
    pre_d = pre_q;
    step  = 1'b0;
    if (clear) begin
      pre_d = '0;
    end else if (count_en) begin
      if (pre_q == PRE_MAX) begin
        pre_d = '0;
        step  = 1'b1;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  // BCD carry chain with rollover detection at 59:59
  always_comb begin
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    wrap_d     = 1'b0;
    running_d  = (state_d == S_RUN);
    if (clear) begin
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      min_ones_d = 4'd0;
      min_tens_d = 4'd0;
    end else if (step) begin
      if (sec_ones_q == 4'd9) begin
        sec_ones_d = 4'd0;
        if (sec_tens_q == 4'd5) begin
          sec_tens_d = 4'd0;
          if (min_ones_q == 4'd9) begin
            min_ones_d = 4'd0;
            if (min_tens_q == 4'd5) begin
              min_tens_d = 4'd0;
              wrap_d     = 1'b1;
            end else begin
              min_tens_d = min_tens_q + 4'd1;
            end
          end else begin
            min_ones_d = min_ones_q + 4'd1;
          end
        end else begin
          sec_tens_d = sec_tens_q + 4'd1;
        end
      end else begin
        sec_ones_d = sec_ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tick_q     <= 1'b0;
      pre_q      <= '0;
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      min_tens_q <= 4'd0;
      running_q  <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_in;
      pre_q      <= pre_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      running_q  <= running_d;
      wrap_q     <= wrap_d;
    end
  end

  assign sec_ones = sec_ones_q;
  assign sec_tens = sec_tens_q;
  assign min_ones = min_ones_q;
  assign min_tens = min_tens_q;
  assign running  = running_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_tick_stopwatch.sv
// Bench for tick_stopwatch: two instances (1 and 3 ticks per step) on shared stimulus,
// a seconds-count scoreboard checked every cycle, a vector table and directed corner sequences.
module tb_tick_stopwatch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, tick_in = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [3:0] so1, st1, mo1, mt1, so3, st3, mo3, mt3;
  logic run1, wrap1, run3, wrap3;
  logic [15:0] d1, d3;

  assign d1 = {mt1, mo1, st1, so1};
  assign d3 = {mt3, mo3, st3, so3};

  int checks = 0;
  int errors = 0;

  tick_stopwatch #(.TICKS_PER_STEP(1), .PRE_W(10)) u1 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .stop(stop), .clear(clear),
    .sec_ones(so1), .sec_tens(st1), .min_ones(mo1), .min_tens(mt1),
    .running(run1), .wrap(wrap1)
  );

  tick_stopwatch #(.TICKS_PER_STEP(3), .PRE_W(10)) u3 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .stop(stop), .clear(clear),
    .sec_ones(so3), .sec_tens(st3), .min_ones(mo3), .min_tens(mt3),
    .running(run3), .wrap(wrap3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] bcd(input int s);
    int m, x;
    m = s / 60;
    x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  // Reference model keeps elapsed time as a plain seconds count.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

  typedef struct packed {
    logic [15:0] d;
    logic        run;
    logic        wrap;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  int   m_st[2];
  int   m_pre[2];
  int   m_secs[2];
  bit   armed = 1'b0;
  logic m_tq = 1'b0;

  always @(posedge clk) begin
    automatic bit   rise;
    automatic bit   cnt;
    automatic bit   w;
    automatic int   tps;
    automatic exp_t e;
    if (rst) armed = 1'b1;
    rise = tick_in && !m_tq;
    for (int k = 0; k < 2; k++) begin
      tps = (k == 0) ? 1 : 3;
      w   = 1'b0;
      if (rst) begin
        m_st[k]   = M_IDLE;
        m_pre[k]  = 0;
        m_secs[k] = 0;
      end else begin
        cnt = (m_st[k] == M_RUN) && rise && !stop && !clear;
        if (clear) begin
          m_secs[k] = 0;
          m_pre[k]  = 0;
        end else if (cnt) begin
          if (m_pre[k] == tps - 1) begin
            m_pre[k] = 0;
            if (m_secs[k] == 3599) begin
              m_secs[k] = 0;
              w = 1'b1;
            end else begin
              m_secs[k]++;
            end
          end else begin
            m_pre[k]++;
          end
        end
        if (clear) m_st[k] = M_IDLE;
        else if (stop) begin
          if (m_st[k] == M_RUN) m_st[k] = M_PAUSE;
        end else if (start && m_st[k] != M_RUN) m_st[k] = M_RUN;
      end
      e.d    = bcd(m_secs[k]);
      e.run  = (m_st[k] == M_RUN);
      e.wrap = w;
      if (armed) begin
        if (k == 0) sb0.push_back(e);
        else        sb1.push_back(e);
      end
    end
    m_tq = rst ? 1'b0 : tick_in;
  end

  always @(negedge clk) begin
    exp_t e;
    if (armed) begin
      if (sb0.size() == 0) check("sb_u1_empty", 32'd0, 32'd1);
      else begin
        e = sb0.pop_front();
        check("sb_u1", {13'd0, d1, run1, wrap1}, {13'd0, e.d, e.run, e.wrap});
      end
      if (sb1.size() == 0) check("sb_u3_empty", 32'd0, 32'd1);
      else begin
        e = sb1.pop_front();
        check("sb_u3", {13'd0, d3, run3, wrap3}, {13'd0, e.d, e.run, e.wrap});
      end
    end
  end

  task automatic pulse(input bit s, input bit p, input bit c);
    @(negedge clk);
    start = s; stop = p; clear = c;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  task automatic rises(input int n);
    repeat (n) begin
      @(negedge clk);
      tick_in = 1'b1;
      @(negedge clk);
      tick_in = 1'b0;
    end
  endtask

  typedef struct {
    bit s, p, c;
    int n;
    int e1, e3;
    bit run;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{s: 1, p: 0, c: 0, n: 12, e1: 12, e3: 4, run: 1};
    tbl[1] = '{s: 0, p: 0, c: 1, n: 0,  e1: 0,  e3: 0, run: 0};
    tbl[2] = '{s: 1, p: 0, c: 0, n: 7,  e1: 7,  e3: 2, run: 1};
    tbl[3] = '{s: 0, p: 1, c: 0, n: 5,  e1: 7,  e3: 2, run: 0};
    tbl[4] = '{s: 1, p: 0, c: 0, n: 2,  e1: 9,  e3: 3, run: 1};
    tbl[5] = '{s: 0, p: 0, c: 1, n: 0,  e1: 0,  e3: 0, run: 0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_digits", {16'd0, d1}, 32'd0);
    check("reset_running", {31'd0, run1}, 32'd0);

    // Free-running tick with no start: nothing may count.
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      tick_in = ((c % 2000) >= 1000);
    end
    @(negedge clk);
    tick_in = 1'b0;
    check("idle_digits_u1", {16'd0, d1}, 32'd0);
    check("idle_digits_u3", {16'd0, d3}, 32'd0);
    check("idle_running", {31'd0, run1}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].s || tbl[i].p || tbl[i].c) pulse(tbl[i].s, tbl[i].p, tbl[i].c);
      rises(tbl[i].n);
      check($sformatf("tbl%0d_u1", i), {16'd0, d1}, {16'd0, bcd(tbl[i].e1)});
      check($sformatf("tbl%0d_u3", i), {16'd0, d3}, {16'd0, bcd(tbl[i].e3)});
      check($sformatf("tbl%0d_run", i), {30'd0, run1, run3}, {30'd0, tbl[i].run, tbl[i].run});
    end

    // Rollover at 59:59
    pulse(1'b1, 1'b0, 1'b0);
    rises(3598);
    check("pre_5958", {16'd0, d1}, 32'h5958);
    rises(1);
    check("at_5959", {16'd0, d1}, 32'h5959);
    check("no_wrap_5959", {31'd0, wrap1}, 32'd0);
    @(negedge clk);
    tick_in = 1'b1;
    @(negedge clk);
    tick_in = 1'b0;
    check("wrap_digits", {16'd0, d1}, 32'd0);
    check("wrap_pulse", {31'd0, wrap1}, 32'd1);
    @(negedge clk);
    check("wrap_single", {31'd0, wrap1}, 32'd0);
    rises(1);
    check("after_wrap", {16'd0, d1}, 32'h0001);
    check("after_wrap_run", {31'd0, run1}, 32'd1);

    // stop with a coincident rise, start+stop in PAUSE, clear+start
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    rises(2);
    check("pre_stop", {16'd0, d1}, 32'h0002);
    @(negedge clk);
    tick_in = 1'b1; stop = 1'b1;
    @(negedge clk);
    tick_in = 1'b0; stop = 1'b0;
    check("stop_rise_digits", {16'd0, d1}, 32'h0002);
    check("stop_rise_run", {31'd0, run1}, 32'd0);
    pulse(1'b1, 1'b1, 1'b0);
    check("start_stop_pause", {31'd0, run1}, 32'd0);
    rises(1);
    check("paused_hold", {16'd0, d1}, 32'h0002);
    pulse(1'b1, 1'b0, 1'b1);
    check("clear_start_run", {31'd0, run1}, 32'd0);
    check("clear_start_digits", {16'd0, d1}, 32'd0);
    rises(1);
    check("idle_after_clear", {16'd0, d1}, 32'd0);

    // Reset mid-count
    pulse(1'b1, 1'b0, 1'b0);
    rises(37);
    check("count_37", {16'd0, d1}, 32'h0037);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_digits", {16'd0, d1}, 32'd0);
    check("rst_running", {31'd0, run1}, 32'd0);
    rises(3);
    check("rst_idle_hold", {16'd0, d1}, 32'd0);
    @(negedge clk);
    start = 1'b1; tick_in = 1'b1;
    @(negedge clk);
    start = 1'b0; tick_in = 1'b0;
    check("start_rise_dropped", {16'd0, d1}, 32'd0);
    check("start_rise_run", {31'd0, run1}, 32'd1);
    rises(1);
    check("post_rst_count", {16'd0, d1}, 32'h0001);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
